// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
// CSR addresses, cause codes, write/set/clear encodings and mstatus bit positions.
package trap_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_T_MEPC,
        S_T_MCAUSE,
        S_T_MTVAL,
        S_T_MSTATUS,
        S_T_VECTOR,
        S_R_MSTATUS,
        S_R_VECTOR
    } trap_state_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam logic [31:0] CAUSE_ILLEGAL  = 32'd2;
    localparam logic [31:0] CAUSE_L_ACCESS = 32'd5;
    localparam logic [31:0] CAUSE_S_ACCESS = 32'd7;
    localparam logic [31:0] CAUSE_ECALL_M  = 32'd11;
    localparam logic [31:0] CAUSE_IRQ      = 32'h8000_000B;

    localparam logic [1:0] WSC_WRITE = 2'b01;
    localparam logic [1:0] WSC_SET   = 2'b10;
    localparam logic [1:0] WSC_CLEAR = 2'b11;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/trap_cause_encoder.sv
// Combinational priority encoder: picks the winning trap event and its cause code.
// Interrupts only win when MIE is set; ecall and interrupts carry a zero trap value.
import trap_pkg::*;

module trap_cause_encoder (
    input  logic        interrupt,
    input  logic        illegal_inst,
    input  logic        l_access_fault,
    input  logic        s_access_fault,
    input  logic        ecall_m,
    input  logic        mie,
    output logic        take,
    output logic        is_irq,
    output logic        tval_zero,
    output logic [31:0] cause
);

    always_comb begin
        take      = 1'b1;
        is_irq    = 1'b0;
        tval_zero = 1'b0;
        cause     = '0;
        if (interrupt && mie) begin
            is_irq    = 1'b1;
            tval_zero = 1'b1;
            cause     = CAUSE_IRQ;
        end else if (illegal_inst) begin
            cause = CAUSE_ILLEGAL;
        end else if (ecall_m) begin
            tval_zero = 1'b1;
            cause     = CAUSE_ECALL_M;
        end else if (l_access_fault) begin
            cause = CAUSE_L_ACCESS;
        end else if (s_access_fault) begin
            cause = CAUSE_S_ACCESS;
        end else begin
            take = 1'b0;
        end
    end

endmodule

// File: rtl/trap_controller.sv
// Owns the CSR port: passes CSR instructions through in IDLE, otherwise sequences trap/mret writes.
// Trap takes 6 cycles (detect + 4 writes + vector), mret takes 3; the pipeline is stalled meanwhile.
import trap_pkg::*;

module trap_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_rw_in,
    input  logic [1:0]  csr_wsc_mode_in,
    input  logic [11:0] csr_rw_addr_in,
    input  logic [31:0] csr_w_data_in,
    output logic        csr_grant,
    input  logic        interrupt,
    input  logic        illegal_inst,
    input  logic        l_access_fault,
    input  logic        s_access_fault,
    input  logic        ecall_m,
    input  logic        mret,
    input  logic [31:0] epc_cur,
    input  logic [31:0] epc_next,
    input  logic [31:0] mtval_in,
    output logic        csr_w,
    output logic [11:0] csr_waddr,
    output logic [11:0] csr_raddr,
    output logic [31:0] csr_wdata,
    output logic [1:0]  csr_wsc,
    input  logic [31:0] csr_rdata,
    input  logic [31:0] mstatus,
    output logic [31:0] PC_redirect,
    output logic        redirect_mux,
    output logic        reg_FD_flush,
    output logic        reg_DE_flush,
    output logic        reg_EM_flush,
    output logic        reg_MW_flush,
    output logic        RegWrite_cancel,
    output logic        stall_pipe
);

    trap_state_t state_q, state_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] tval_q, tval_d;

    logic        take, is_irq, tval_zero;
    logic [31:0] enc_cause;
    logic [31:0] ms_trap, ms_ret;

    trap_cause_encoder u_enc (
        .interrupt      (interrupt),
        .illegal_inst   (illegal_inst),
        .l_access_fault (l_access_fault),
        .s_access_fault (s_access_fault),
        .ecall_m        (ecall_m),
        .mie            (mstatus[MSTATUS_MIE]),
        .take           (take),
        .is_irq         (is_irq),
        .tval_zero      (tval_zero),
        .cause          (enc_cause)
    );

    always_comb begin
        ms_trap                               = mstatus;
        ms_trap[MSTATUS_MPIE]                 = mstatus[MSTATUS_MIE];
        ms_trap[MSTATUS_MIE]                  = 1'b0;
        ms_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        ms_ret                                = mstatus;
        ms_ret[MSTATUS_MIE]                   = mstatus[MSTATUS_MPIE];
        ms_ret[MSTATUS_MPIE]                  = 1'b1;
    end

    // Outputs are held at zero while reset is asserted, including IDLE pass-through.
    always_comb begin
        state_d         = state_q;
        cause_d         = cause_q;
        epc_d           = epc_q;
        tval_d          = tval_q;
        csr_grant       = 1'b0;
        csr_w           = 1'b0;
        csr_waddr       = '0;
        csr_raddr       = '0;
        csr_wdata       = '0;
        csr_wsc         = '0;
        PC_redirect     = '0;
        redirect_mux    = 1'b0;
        reg_FD_flush    = 1'b0;
        reg_DE_flush    = 1'b0;
        reg_EM_flush    = 1'b0;
        reg_MW_flush    = 1'b0;
        RegWrite_cancel = 1'b0;
        stall_pipe      = 1'b0;
        if (rst) begin
            case (state_q)
                S_IDLE: begin
                    if (take || mret) begin
                        reg_FD_flush    = 1'b1;
                        reg_DE_flush    = 1'b1;
                        reg_EM_flush    = 1'b1;
                        reg_MW_flush    = 1'b1;
                        RegWrite_cancel = !is_irq;
                        if (take) begin
                            state_d = S_T_MEPC;
                            cause_d = enc_cause;
                            epc_d   = is_irq ? epc_next : epc_cur;
                            tval_d  = tval_zero ? 32'd0 : mtval_in;
                        end else begin
                            state_d = S_R_MSTATUS;
                        end
                    end else if (csr_rw_in) begin
                        csr_grant = 1'b1;
                        csr_w     = 1'b1;
                        csr_waddr = csr_rw_addr_in;
                        csr_raddr = csr_rw_addr_in;
                        csr_wdata = csr_w_data_in;
                        csr_wsc   = csr_wsc_mode_in;
                    end
                end
                S_T_MEPC, S_T_MCAUSE, S_T_MTVAL, S_T_MSTATUS, S_R_MSTATUS: begin
                    stall_pipe = 1'b1;
                    csr_w      = 1'b1;
                    csr_wsc    = WSC_WRITE;
                    case (state_q)
                        S_T_MEPC:   begin csr_waddr = CSR_MEPC;    csr_wdata = epc_q;   state_d = S_T_MCAUSE;  end
                        S_T_MCAUSE: begin csr_waddr = CSR_MCAUSE;  csr_wdata = cause_q; state_d = S_T_MTVAL;   end
                        S_T_MTVAL:  begin csr_waddr = CSR_MTVAL;   csr_wdata = tval_q;  state_d = S_T_MSTATUS; end
                        S_T_MSTATUS: begin csr_waddr = CSR_MSTATUS; csr_wdata = ms_trap; state_d = S_T_VECTOR; end
                        default:    begin csr_waddr = CSR_MSTATUS; csr_wdata = ms_ret;  state_d = S_R_VECTOR;  end
                    endcase
                end
                S_T_VECTOR, S_R_VECTOR: begin
                    stall_pipe   = 1'b1;
                    reg_FD_flush = 1'b1;
                    redirect_mux = 1'b1;
                    csr_raddr    = (state_q == S_T_VECTOR) ? CSR_MTVEC : CSR_MEPC;
                    PC_redirect  = csr_rdata;
                    state_d      = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cause_q <= '0;
            epc_q   <= '0;
            tval_q  <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
            tval_q  <= tval_d;
        end
    end

endmodule
